mole_spawner: RTL and testbench
===============================

MOLE_SPAWNER -- requirements
Module: mole_spawner

Interface
REQ-001 The block SHALL have parameter NUM_HOLES, default 18, giving the number of holes and the width of the mole vector.
REQ-002 The block SHALL have parameter NUM_MOLES, default 3, giving the number of distinct moles raised per round; legal range is 1..NUM_HOLES.
REQ-003 The block SHALL have parameter CLKS_PER_MS, default 50000, giving the number of clock cycles per millisecond.
REQ-004 The block SHALL have parameter MOLE_UP_MS, default 1000, giving the duration of the UP phase in ms.
REQ-005 The block SHALL have parameter MOLE_DOWN_MS, default 1000, giving the duration of the DOWN phase in ms.
REQ-006 The block SHALL have port clk, input, width 1: the single system clock; all logic uses its rising edge.
REQ-007 The block SHALL have port rst, input, width 1: asynchronous, active-low reset.
REQ-008 The block SHALL have port enable, input, width 1: game in progress.
REQ-009 The block SHALL have port hit_mask, input, width NUM_HOLES: single-cycle pulses, one bit per hole whacked.
REQ-010 The block SHALL have port mole_positions, output, width NUM_HOLES: one bit per raised mole, registered.
REQ-011 The block SHALL have port spawn_pulse, output, width 1: a one-cycle pulse on the first cycle of each UP phase.
REQ-012 The block SHALL have port mole_up, output, width 1: high while in the UP state.

Function
REQ-013 The FSM SHALL have states IDLE, DOWN, PICK and UP.
REQ-014 IDLE SHALL go to DOWN when enable=1; DOWN SHALL go to PICK after MOLE_DOWN_MS ms; PICK SHALL go to UP once NUM_MOLES holes are chosen; UP SHALL go to DOWN after MOLE_UP_MS ms.
REQ-015 enable=0 in any state SHALL force IDLE on the next edge, clear mole_positions and reset the timers; the LFSR SHALL keep its value.
REQ-016 Timing SHALL use a prescaler counting 0..CLKS_PER_MS-1 and a ms counter, both cleared on every state entry, so DOWN lasts exactly MOLE_DOWN_MS*CLKS_PER_MS cycles and UP lasts exactly MOLE_UP_MS*CLKS_PER_MS cycles.
REQ-017 A 16-bit Fibonacci LFSR with taps 16,14,13,11 SHALL advance once per cycle while enable=1 and SHALL never hold zero.
REQ-018 In PICK, each cycle SHALL take candidate = LFSR[$clog2(NUM_HOLES)-1:0]; the candidate SHALL be rejected if it is >= NUM_HOLES or its bit is already set, and otherwise its bit SHALL be set in a pending mask and the pick count incremented.
REQ-019 mole_positions SHALL stay 0 during PICK; the pending mask SHALL be copied to mole_positions on the same edge that enters UP, with spawn_pulse=1 for that cycle.
REQ-020 In UP, hit_mask bits SHALL clear the matching mole_positions bits on the next edge; hit_mask bits for unraised holes SHALL be ignored; hit_mask outside UP SHALL be ignored.
REQ-021 Leaving UP SHALL clear mole_positions on the same edge.
REQ-022 A hit on the final ms-expiry cycle of UP SHALL be taken as a normal hit and the state SHALL exit UP on that edge.
REQ-023 popcount(mole_positions) SHALL equal NUM_MOLES on UP entry and SHALL never exceed it.

Reset
REQ-024 While rst=0, the block SHALL set state=IDLE, mole_positions=0, spawn_pulse=0, mole_up=0, counters=0 and LFSR=16'hACE1, asynchronously.
REQ-025 Release of rst SHALL take effect at the next clock edge; reset asserted mid-PICK or mid-UP SHALL discard all moles.

Configuration
REQ-026 With macro MOLE_SPAWNER_FULL_CLEAR_EN defined, UP SHALL end early, with a transition to DOWN on the edge after mole_positions becomes 0 through hits.
REQ-027 Without MOLE_SPAWNER_FULL_CLEAR_EN, UP SHALL always last the full MOLE_UP_MS even when all moles are hit.

Verification
REQ-028 Bench parameters SHALL be CLKS_PER_MS=2, MOLE_UP_MS=3 and MOLE_DOWN_MS=2, with defaults for the hole and mole counts; all scenarios below use these values.
REQ-029 Scenario 1: rst low then released, enable=1 -> the bench observes exactly 4 DOWN cycles, PICK, then spawn_pulse for 1 cycle with popcount(mole_positions)=3, and mole_up high for exactly 6 cycles.
REQ-030 Scenario 2: in UP, pulse hit_mask on one raised bit and one unraised bit -> only the raised bit clears; popcount becomes 2.
REQ-031 Scenario 3: hit all 3 moles on UP cycle 2 -> with the macro, DOWN is entered on the next edge; without it, mole_up stays high until cycle 6.
REQ-032 Scenario 4: drop enable mid-UP -> IDLE, mole_positions=0 next edge; re-raise enable -> DOWN restarts with a full 4 cycles.
REQ-033 Scenario 5: run 1000 rounds -> every round has 3 distinct bits, all indices < 18, and no round exceeds 64 PICK cycles.
REQ-034 Scenario 6: assert rst during PICK -> outputs are 0 immediately (asynchronously) and LFSR=16'hACE1.

Source files
------------

// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: IDLE/DOWN/PICK/UP round sequencer with LFSR-driven hole selection.
// Optional macro MOLE_SPAWNER_FULL_CLEAR_EN ends the UP phase early once every mole has been hit.
module mole_spawner #(
  parameter int NUM_HOLES    = 18,
  parameter int NUM_MOLES    = 3,
  parameter int CLKS_PER_MS  = 50000,
  parameter int MOLE_UP_MS   = 1000,
  parameter int MOLE_DOWN_MS = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_HOLES-1:0] hit_mask,
  output logic [NUM_HOLES-1:0] mole_positions,
  output logic                 spawn_pulse,
  output logic                 mole_up
);

  localparam int CAND_W = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
  localparam int PRE_W  = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int MS_MAX = (MOLE_UP_MS > MOLE_DOWN_MS) ? MOLE_UP_MS : MOLE_DOWN_MS;
  localparam int MS_W   = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
  localparam int CNT_W  = $clog2(NUM_MOLES + 1);

  localparam logic [15:0]      LFSR_SEED = 16'hACE1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLKS_PER_MS - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO  = PRE_W'(0);
  localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
  localparam logic [MS_W-1:0]  DOWN_LAST = MS_W'(MOLE_DOWN_MS - 1);
  localparam logic [MS_W-1:0]  UP_LAST   = MS_W'(MOLE_UP_MS - 1);
  localparam logic [MS_W-1:0]  MS_ZERO   = MS_W'(0);
  localparam logic [MS_W-1:0]  MS_ONE    = MS_W'(1);
  localparam logic [CNT_W-1:0] PICK_LAST = CNT_W'(NUM_MOLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [NUM_HOLES-1:0] HOLES_ZERO = {NUM_HOLES{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    PICK = 2'd2,
    UP   = 2'd3
  } state_t;

  state_t               state_r;
  logic [15:0]          lfsr_r;
  logic [PRE_W-1:0]     presc_r;
  logic [MS_W-1:0]      ms_r;
  logic [CNT_W-1:0]     pick_cnt_r;
  logic [NUM_HOLES-1:0] pending_r;

  logic [CAND_W-1:0]    cand_s;
  logic [NUM_HOLES-1:0] cand_onehot_s;
  logic                 cand_ok_s;
  logic                 pre_last_s;
  logic                 timer_done_s;
  logic                 up_exit_s;

  // Fibonacci step, taps 16,14,13,11; the zero guard keeps a corrupted register from locking up.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic        fb;
    logic [15:0] nxt;
    fb  = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
    nxt = {cur[14:0], fb};
    return (nxt == 16'h0000) ? LFSR_SEED : nxt;
  endfunction

  // LFSR free-runs whenever the game is enabled and holds its value otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_r <= LFSR_SEED;
    end else if (enable) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Candidate decode: out-of-range indices decode to an all-zero one-hot and are rejected.
  always_comb begin
    cand_s        = lfsr_r[CAND_W-1:0];
    cand_onehot_s = HOLES_ZERO;
    for (int i = 0; i < NUM_HOLES; i++) begin
      cand_onehot_s[i] = (cand_s == CAND_W'(i));
    end
    cand_ok_s = (|cand_onehot_s) && !(|(cand_onehot_s & pending_r));
  end

  // Phase timer expiry and the UP exit condition.
  always_comb begin
    timer_done_s = 1'b0;
    pre_last_s   = (presc_r == PRE_LAST);
    case (state_r)
      DOWN:    timer_done_s = pre_last_s && (ms_r == DOWN_LAST);
      UP:      timer_done_s = pre_last_s && (ms_r == UP_LAST);
      default: timer_done_s = 1'b0;
    endcase
`ifdef MOLE_SPAWNER_FULL_CLEAR_EN
    up_exit_s = timer_done_s || (mole_positions == HOLES_ZERO);
`else
    up_exit_s = timer_done_s;
`endif
  end

  // Main sequencer; all outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      mole_positions <= HOLES_ZERO;
      spawn_pulse    <= 1'b0;
      mole_up        <= 1'b0;
      presc_r        <= PRE_ZERO;
      ms_r           <= MS_ZERO;
      pick_cnt_r     <= CNT_ZERO;
      pending_r      <= HOLES_ZERO;
    end else if (!enable) begin
      state_r        <= IDLE;
      mole_positions <= HOLES_ZERO;
      spawn_pulse    <= 1'b0;
      mole_up        <= 1'b0;
      presc_r        <= PRE_ZERO;
      ms_r           <= MS_ZERO;
      pick_cnt_r     <= CNT_ZERO;
      pending_r      <= HOLES_ZERO;
    end else begin
      spawn_pulse <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r        <= DOWN;
          mole_positions <= HOLES_ZERO;
          mole_up        <= 1'b0;
          presc_r        <= PRE_ZERO;
          ms_r           <= MS_ZERO;
        end

        DOWN: begin
          mole_positions <= HOLES_ZERO;
          mole_up        <= 1'b0;
          if (timer_done_s) begin
            state_r    <= PICK;
            presc_r    <= PRE_ZERO;
            ms_r       <= MS_ZERO;
            pick_cnt_r <= CNT_ZERO;
            pending_r  <= HOLES_ZERO;
          end else if (pre_last_s) begin
            presc_r <= PRE_ZERO;
            ms_r    <= ms_r + MS_ONE;
          end else begin
            presc_r <= presc_r + PRE_ONE;
          end
        end

        PICK: begin
          mole_positions <= HOLES_ZERO;
          mole_up        <= 1'b0;
          if (cand_ok_s) begin
            pending_r <= pending_r | cand_onehot_s;
            if (pick_cnt_r == PICK_LAST) begin
              // Last accepted hole: raise the whole set at once on UP entry.
              state_r        <= UP;
              mole_positions <= pending_r | cand_onehot_s;
              spawn_pulse    <= 1'b1;
              mole_up        <= 1'b1;
              presc_r        <= PRE_ZERO;
              ms_r           <= MS_ZERO;
              pick_cnt_r     <= CNT_ZERO;
            end else begin
              pick_cnt_r <= pick_cnt_r + CNT_ONE;
            end
          end else begin
            pending_r <= pending_r;
          end
        end

        UP: begin
          if (up_exit_s) begin
            state_r        <= DOWN;
            mole_positions <= HOLES_ZERO;
            mole_up        <= 1'b0;
            presc_r        <= PRE_ZERO;
            ms_r           <= MS_ZERO;
          end else begin
            mole_positions <= mole_positions & ~hit_mask;
            mole_up        <= 1'b1;
            if (pre_last_s) begin
              presc_r <= PRE_ZERO;
              ms_r    <= ms_r + MS_ONE;
            end else begin
              presc_r <= presc_r + PRE_ONE;
            end
          end
        end

        default: begin
          state_r        <= IDLE;
          mole_positions <= HOLES_ZERO;
          mole_up        <= 1'b0;
          presc_r        <= PRE_ZERO;
          ms_r           <= MS_ZERO;
          pick_cnt_r     <= CNT_ZERO;
          pending_r      <= HOLES_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// Directed self-checking bench for mole_spawner (CLKS_PER_MS=2, MOLE_UP_MS=3, MOLE_DOWN_MS=2).
module tb_mole_spawner;

  localparam int NH       = 18;
  localparam int NM       = 3;
  localparam int CPM      = 2;
  localparam int UPMS     = 3;
  localparam int DNMS     = 2;
  localparam int DOWN_CYC = CPM * DNMS;
  localparam int UP_CYC   = CPM * UPMS;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [NH-1:0] hit_mask;
  logic [NH-1:0] mole_positions;
  logic          spawn_pulse;
  logic          mole_up;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] lfsr_m;

  mole_spawner #(
    .NUM_HOLES   (NH),
    .NUM_MOLES   (NM),
    .CLKS_PER_MS (CPM),
    .MOLE_UP_MS  (UPMS),
    .MOLE_DOWN_MS(DNMS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .hit_mask      (hit_mask),
    .mole_positions(mole_positions),
    .spawn_pulse   (spawn_pulse),
    .mole_up       (mole_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR: seeded by reset, steps on every edge with enable high.
  always @(posedge clk or negedge rst) begin
    if (!rst) lfsr_m <= 16'hACE1;
    else if (enable) lfsr_m <= nxt(lfsr_m);
  end

  // From the LFSR value seen in the first DOWN cycle, predict PICK length and chosen holes.
  function automatic void predict(input logic [15:0] l0, output int cyc, output logic [NH-1:0] m);
    logic [15:0] l;
    int n;
    int ci;
    l = l0;
    n = 0;
    cyc = 0;
    m = '0;
    for (int k = 0; k < DOWN_CYC; k++) l = nxt(l);
    while (n < NM && cyc < 1000) begin
      ci = int'(l[4:0]);
      cyc++;
      if (ci < NH) begin
        if (!m[ci]) begin
          m[ci] = 1'b1;
          n++;
        end
      end
      l = nxt(l);
    end
  endfunction

  task automatic run_to_spawn(output int cnt, output bit ok);
    cnt = 1;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (spawn_pulse) begin
        ok = 1'b1;
        break;
      end
      cnt++;
    end
  endtask

  task automatic wait_up_end(input int start, output int cnt);
    cnt = start;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!mole_up) break;
      cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; hit_mask = '0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    n_tests++; if (mole_positions !== '0) begin n_fail++; $display("FAIL reset_pos: got %h want 0", mole_positions); end
    n_tests++; if (spawn_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_spawn: got %b want 0", spawn_pulse); end
    n_tests++; if (mole_up !== 1'b0) begin n_fail++; $display("FAIL reset_up: got %b want 0", mole_up); end
    n_tests++; if (dut.lfsr_r !== 16'hACE1) begin n_fail++; $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr_r); end
  endtask

  task automatic test_first_round();
    int pc, cnt, up; bit ok; logic [NH-1:0] pm;
    rst = 1'b1; enable = 1'b1;
    @(negedge clk);
    predict(lfsr_m, pc, pm);
    run_to_spawn(cnt, ok);
    n_tests++; if (!ok || cnt != DOWN_CYC + pc) begin n_fail++; $display("FAIL first_gap: got %0d want %0d", cnt, DOWN_CYC + pc); end
    n_tests++; if (mole_positions !== pm) begin n_fail++; $display("FAIL first_pos: got %h want %h", mole_positions, pm); end
    n_tests++; if ($countones(mole_positions) != NM) begin n_fail++; $display("FAIL first_popcount: got %0d want %0d", $countones(mole_positions), NM); end
    @(negedge clk);
    n_tests++; if (spawn_pulse !== 1'b0 || mole_up !== 1'b1) begin n_fail++; $display("FAIL first_spawn_width: got spawn=%b up=%b want 0/1", spawn_pulse, mole_up); end
    wait_up_end(2, up);
    n_tests++; if (up != UP_CYC) begin n_fail++; $display("FAIL first_up_len: got %0d want %0d", up, UP_CYC); end
    n_tests++; if (mole_positions !== '0) begin n_fail++; $display("FAIL first_exit_pos: got %h want 0", mole_positions); end
  endtask

  task automatic test_partial_hit();
    int pc, cnt, raised, unraised, r2; bit ok; logic [NH-1:0] pm, hm, expv;
    predict(lfsr_m, pc, pm);
    run_to_spawn(cnt, ok);
    n_tests++; if (!ok || mole_positions !== pm) begin n_fail++; $display("FAIL partial_spawn: got %h want %h", mole_positions, pm); end
    raised = -1; unraised = -1;
    for (int i = 0; i < NH; i++) begin
      if (pm[i] && raised < 0) raised = i;
      if (!pm[i] && unraised < 0) unraised = i;
    end
    hm = '0; hm[raised] = 1'b1; hm[unraised] = 1'b1;
    hit_mask = hm;
    @(negedge clk);
    hit_mask = '0;
    expv = pm; expv[raised] = 1'b0;
    n_tests++; if (mole_positions !== expv) begin n_fail++; $display("FAIL partial_pos: got %h want %h", mole_positions, expv); end
    n_tests++; if ($countones(mole_positions) != 2) begin n_fail++; $display("FAIL partial_popcount: got %0d want 2", $countones(mole_positions)); end
    repeat (4) @(negedge clk);
    n_tests++; if (mole_up !== 1'b1 || mole_positions !== expv) begin n_fail++; $display("FAIL partial_cycle6: got up=%b pos=%h want 1/%h", mole_up, mole_positions, expv); end
    r2 = -1;
    for (int i = 0; i < NH; i++) if (expv[i] && r2 < 0) r2 = i;
    hm = '0; hm[r2] = 1'b1;
    hit_mask = hm;
    @(negedge clk);
    hit_mask = '0;
    n_tests++; if (mole_up !== 1'b0 || mole_positions !== '0) begin n_fail++; $display("FAIL final_cycle_hit: got up=%b pos=%h want 0/0", mole_up, mole_positions); end
  endtask

  task automatic test_full_clear();
    int pc, cnt, up, want; bit ok; logic [NH-1:0] pm;
    predict(lfsr_m, pc, pm);
    run_to_spawn(cnt, ok);
    n_tests++; if (!ok || cnt != DOWN_CYC + pc) begin n_fail++; $display("FAIL clear_gap: got %0d want %0d", cnt, DOWN_CYC + pc); end
    @(negedge clk);
    hit_mask = pm;
    @(negedge clk);
    hit_mask = '0;
    n_tests++; if (mole_positions !== '0) begin n_fail++; $display("FAIL clear_pos: got %h want 0", mole_positions); end
    wait_up_end(3, up);
`ifdef MOLE_SPAWNER_FULL_CLEAR_EN
    want = 3;
`else
    want = UP_CYC;
`endif
    n_tests++; if (up != want) begin n_fail++; $display("FAIL clear_up_len: got %0d want %0d", up, want); end
  endtask

  task automatic test_hit_outside_up();
    int pc, cnt, up; bit ok; logic [NH-1:0] pm;
    hit_mask = '1;
    predict(lfsr_m, pc, pm);
    run_to_spawn(cnt, ok);
    hit_mask = '0;
    n_tests++; if (!ok || mole_positions !== pm) begin n_fail++; $display("FAIL outside_hit_pos: got %h want %h", mole_positions, pm); end
    wait_up_end(1, up);
    n_tests++; if (up != UP_CYC) begin n_fail++; $display("FAIL outside_hit_up_len: got %0d want %0d", up, UP_CYC); end
  endtask

  task automatic test_enable_drop();
    int pc, cnt, up; bit ok; logic [NH-1:0] pm;
    predict(lfsr_m, pc, pm);
    run_to_spawn(cnt, ok);
    n_tests++; if (!ok || mole_positions !== pm) begin n_fail++; $display("FAIL drop_spawn: got %h want %h", mole_positions, pm); end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    n_tests++; if (mole_up !== 1'b0 || mole_positions !== '0 || spawn_pulse !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got up=%b pos=%h spawn=%b want 0", mole_up, mole_positions, spawn_pulse); end
    repeat (2) @(negedge clk);
    n_tests++; if (mole_up !== 1'b0 || mole_positions !== '0) begin n_fail++; $display("FAIL drop_hold: got up=%b pos=%h want 0", mole_up, mole_positions); end
    enable = 1'b1;
    @(negedge clk);
    predict(lfsr_m, pc, pm);
    run_to_spawn(cnt, ok);
    n_tests++; if (!ok || cnt != DOWN_CYC + pc) begin n_fail++; $display("FAIL drop_restart_gap: got %0d want %0d", cnt, DOWN_CYC + pc); end
    n_tests++; if (mole_positions !== pm) begin n_fail++; $display("FAIL drop_restart_pos: got %h want %h", mole_positions, pm); end
    wait_up_end(1, up);
  endtask

  task automatic test_many_rounds();
    int pc, cnt, up; bit ok; logic [NH-1:0] pm;
    for (int r = 0; r < 1000; r++) begin
      predict(lfsr_m, pc, pm);
      run_to_spawn(cnt, ok);
      n_tests++; if (!ok || cnt != DOWN_CYC + pc) begin n_fail++; $display("FAIL round%0d_gap: got %0d want %0d", r, cnt, DOWN_CYC + pc); end
      n_tests++; if (mole_positions !== pm || $countones(mole_positions) != NM) begin n_fail++; $display("FAIL round%0d_pos: got %h want %h", r, mole_positions, pm); end
      n_tests++; if (cnt - DOWN_CYC > 64) begin n_fail++; $display("FAIL round%0d_pick_len: got %0d want <=64", r, cnt - DOWN_CYC); end
      wait_up_end(1, up);
      n_tests++; if (up != UP_CYC) begin n_fail++; $display("FAIL round%0d_up_len: got %0d want %0d", r, up, UP_CYC); end
      if (!ok) break;
    end
  endtask

  task automatic test_async_reset();
    int pc, cnt; bit ok; logic [NH-1:0] pm;
    predict(lfsr_m, pc, pm);
    run_to_spawn(cnt, ok);
    #2 rst = 1'b0;
    #1;
    n_tests++; if (mole_positions !== '0 || mole_up !== 1'b0 || spawn_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_up_outputs: got pos=%h up=%b spawn=%b want 0", mole_positions, mole_up, spawn_pulse); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    predict(lfsr_m, pc, pm);
    repeat (DOWN_CYC) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests++; if (mole_positions !== '0 || mole_up !== 1'b0 || spawn_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pick_outputs: got pos=%h up=%b spawn=%b want 0", mole_positions, mole_up, spawn_pulse); end
    n_tests++; if (dut.lfsr_r !== 16'hACE1) begin n_fail++; $display("FAIL rst_pick_lfsr: got %h want ace1", dut.lfsr_r); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    predict(lfsr_m, pc, pm);
    run_to_spawn(cnt, ok);
    n_tests++; if (!ok || cnt != DOWN_CYC + pc || mole_positions !== pm) begin n_fail++; $display("FAIL rst_recover: got gap=%0d pos=%h want %0d/%h", cnt, mole_positions, DOWN_CYC + pc, pm); end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; hit_mask = '0;
    test_reset();
    test_first_round();
    test_partial_hit();
    test_full_clear();
    test_hit_outside_up();
    test_enable_drop();
    test_many_rounds();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
